alu_seq: RTL and testbench



---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_mul_seq.sv | 49 ++++
 rtl/alu_seq.sv | 146 ++++++++++++++
 tb/tb_alu_seq.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the sequential ALU: opcodes, FSM states and flag-vector indices.
package alu_pkg;

    localparam int OPW = 4;

    localparam logic [OPW-1:0] OP_ADD = 4'd0;
    localparam logic [OPW-1:0] OP_SUB = 4'd1;
    localparam logic [OPW-1:0] OP_AND = 4'd2;
    localparam logic [OPW-1:0] OP_OR  = 4'd3;
    localparam logic [OPW-1:0] OP_XOR = 4'd4;
    localparam logic [OPW-1:0] OP_SHL = 4'd5;
    localparam logic [OPW-1:0] OP_SHR = 4'd6;
    localparam logic [OPW-1:0] OP_ADC = 4'd7;
    localparam logic [OPW-1:0] OP_MUL = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MUL_RUN = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    localparam int FL_C = 0;
    localparam int FL_Z = 1;
    localparam int FL_N = 2;
    localparam int FL_V = 3;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per clock, WIDTH steps after start.
module alu_mul_seq #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    logic               busy;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= CW'(WIDTH - 1);
        end else if (busy) begin
            if (cnt == '0) busy <= 1'b0;
            else           cnt  <= cnt - 1'b1;
        end
    end

    // Datapath carries no reset; it is fully reloaded on every start.
    always_ff @(posedge clk) begin
        if (start) begin
            mcand   <= {{WIDTH{1'b0}}, A};
            mplier  <= B;
            product <= '0;
        end else if (busy) begin
            if (mplier[0]) product <= product + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    // High during the final step; product is complete on the following cycle.
    assign done = busy && (cnt == '0);

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes; single-cycle ops plus a sequenced multiply.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    state_t               state, state_nx;
    logic                 mul_start, mul_done, load_alu, load_mul;
    logic [2*WIDTH-1:0]   product;
    logic                 carry_reg;
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     alu_res, nx_res;
    logic                 alu_c, alu_v;
    logic [3:0]           nx_fl;

    function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] r,
                                              input logic c, input logic v);
        logic [3:0] f;
        f       = '0;
        f[FL_C] = c;
        f[FL_Z] = (r == '0);
        f[FL_N] = r[WIDTH-1];
        f[FL_V] = v;
        return f;
    endfunction

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .A       (A),
        .B       (B),
        .done    (mul_done),
        .product (product)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        mul_start = 1'b0;
        load_alu  = 1'b0;
        load_mul  = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = rst_n && (!out_valid || out_ready);
                if (in_valid && in_ready) begin
                    if (opcode == OP_MUL) begin
                        mul_start = 1'b1;
                        state_nx  = S_MUL_RUN;
                    end else begin
                        load_alu = 1'b1;
                    end
                end
            end
            S_MUL_RUN: if (mul_done) state_nx = S_DONE;
            S_DONE: begin
                load_mul = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Single-cycle ops; the WIDTH+1 sum exposes carry/borrow and the shifted-out bit.
    always_comb begin
        sum     = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (opcode)
            OP_ADD, OP_ADC: begin
                sum = {1'b0, A} + {1'b0, B}
                    + {{WIDTH{1'b0}}, (opcode == OP_ADC) ? carry_reg : 1'b0};
                {alu_c, alu_res} = sum;
                alu_v = (A[WIDTH-1] == B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                sum = {1'b0, A} - {1'b0, B};
                {alu_c, alu_res} = sum;
                alu_v = (A[WIDTH-1] != B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND: alu_res = A & B;
            OP_OR:  alu_res = A | B;
            OP_XOR: alu_res = A ^ B;
            OP_SHL: begin
                sum = {1'b0, A} << B[SHW-1:0];
                {alu_c, alu_res} = sum;
            end
            OP_SHR: begin
                sum     = {A, 1'b0} >> B[SHW-1:0];
                alu_res = sum[WIDTH:1];
                alu_c   = sum[0];
            end
            default: ;
        endcase
    end

    assign nx_res = load_mul ? product[WIDTH-1:0] : alu_res;
    assign nx_fl  = load_mul ? pack_flags(product[WIDTH-1:0], |product[2*WIDTH-1:WIDTH], 1'b0)
                             : pack_flags(alu_res, alu_c, alu_v);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            neg       <= 1'b0;
            ovf       <= 1'b0;
            carry_reg <= 1'b0;
        end else if (load_alu || load_mul) begin
            out_valid <= 1'b1;
            result    <= nx_res;
            carry     <= nx_fl[FL_C];
            zero      <= nx_fl[FL_Z];
            neg       <= nx_fl[FL_N];
            ovf       <= nx_fl[FL_V];
            carry_reg <= nx_fl[FL_C];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=8.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a, b;
    logic [3:0] opcode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       carry, zero, neg, ovf;

    int passed = 0;
    int total  = 0;

    alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .B         (b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic issue(input logic [3:0] op, input logic [7:0] va, input logic [7:0] vb);
        opcode   = op;
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        int  lat;
        logic seen, rdy_low;

        rst_n = 1'b0; in_valid = 1'b1; opcode = 4'd0; a = 8'h01; b = 8'h01; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_out_valid", out_valid, 0);
            chk("rst_flags", {carry, zero, neg, ovf}, 0);
            chk("rst_result", result, 0);
            chk("rst_in_ready", in_ready, 0);
        end
        rst_n = 1'b1; in_valid = 1'b0;
        tick();
        chk("idle_in_ready", in_ready, 1);
        chk("idle_out_valid", out_valid, 0);

        issue(4'd0, 8'hF0, 8'h20);
        chk("add1_valid", out_valid, 1);
        chk("add1_result", result, 8'h10);
        chk("add1_cvzn", {carry, ovf, zero, neg}, 4'b1000);

        issue(4'd0, 8'h7F, 8'h01);
        chk("add2_result", result, 8'h80);
        chk("add2_cvzn", {carry, ovf, zero, neg}, 4'b0101);

        issue(4'd1, 8'h05, 8'h07);
        chk("sub_result", result, 8'hFE);
        chk("sub_cvzn", {carry, ovf, zero, neg}, 4'b1001);

        issue(4'd7, 8'h01, 8'h01);
        chk("adc_result", result, 8'h03);
        chk("adc_cvzn", {carry, ovf, zero, neg}, 4'b0000);

        issue(4'd8, 8'h12, 8'h10);
        lat = 0; rdy_low = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            if (!out_valid && in_ready) rdy_low = 1'b0;
            if (out_valid) begin
                lat = i - 1;
                break;
            end
            tick();
        end
        chk("mul_latency", lat, 9);
        chk("mul_in_ready_low", rdy_low, 1);
        chk("mul_result", result, 8'h20);
        chk("mul_cvzn", {carry, ovf, zero, neg}, 4'b1000);

        issue(4'd8, 8'h03, 8'h03);
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("mul_abort_no_valid", seen, 0);
        chk("mul_abort_idle", in_ready, 1);

        out_ready = 1'b0;
        issue(4'd4, 8'hAA, 8'h0F);
        chk("xor_valid", out_valid, 1);
        chk("xor_result", result, 8'hA5);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_result_stable", result, 8'hA5);
            chk("bp_valid_held", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #0;
        chk("bp_release_ready", in_ready, 1);
        issue(4'd5, 8'h81, 8'h01);
        chk("shl_valid", out_valid, 1);
        chk("shl_result", result, 8'h02);
        chk("shl_carry", carry, 1);

        issue(4'd6, 8'h81, 8'h01);
        chk("shr_result", result, 8'h40);
        chk("shr_carry", carry, 1);

        issue(4'd12, 8'hFF, 8'h01);
        chk("op12_valid", out_valid, 1);
        chk("op12_result", result, 8'h00);
        chk("op12_flags", {carry, zero, ovf}, 3'b010);

        tick();
        chk("drain_valid", out_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
